// File: rtl/vproc_mem_responder_pkg.sv
// Shared VProc responder definitions: FSM state encoding, default control
// register address and wait-counter sizing used by the responder and its bench.
package vproc_mem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [31:0] DEFAULT_CTRL_ADDR = 32'hAFFF_FFF0;

  localparam int WAIT_CNT_W = 8;

  // Where a read ACK sources DataIn from.
  typedef enum logic {
    RD_SRC_REG = 1'b0,
    RD_SRC_RAM = 1'b1
  } rd_src_e;

endpackage

// File: rtl/vproc_mem_responder_if.sv
// Processor-side bus between a VProc master and the memory responder.
interface vproc_mem_responder_if #(
  parameter int INT_WIDTH = 3
);
  logic [31:0]          addr;
  logic                 we;
  logic                 rd;
  logic [31:0]          data_out;
  logic [11:0]          burst;
  logic                 burst_first;
  logic                 burst_last;
  logic [31:0]          data_in;
  logic                 wr_ack;
  logic                 rd_ack;
  logic [INT_WIDTH-1:0] interrupt;
  logic [15:0]          err_count;

  modport master (
    output addr, we, rd, data_out, burst, burst_first, burst_last,
    input  data_in, wr_ack, rd_ack, interrupt, err_count
  );

  modport slave (
    input  addr, we, rd, data_out, burst, burst_first, burst_last,
    output data_in, wr_ack, rd_ack, interrupt, err_count
  );
endinterface

// File: rtl/vproc_mem_ram.sv
// Single-port word RAM: synchronous write, registered read with read enable.
module vproc_mem_ram #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0] i_wdata,
  output logic [DWIDTH-1:0] o_rdata
);

  logic [DWIDTH-1:0] r_mem [2**AWIDTH];
  logic [DWIDTH-1:0] r_rdata;

  // NOTE: no reset on the array or its read register, so it maps onto block RAM
  // and its contents survive a responder reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vproc_mem_responder.sv
// Memory/interrupt-register responder for a VProc bus master, with configurable
// first-beat and in-burst wait states and a saturating error counter.
module vproc_mem_responder
  import vproc_mem_responder_pkg::*;
#(
  parameter int          MEM_AWIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] CTRL_ADDR  = DEFAULT_CTRL_ADDR,
  parameter int          FIRST_WAIT = 2,
  parameter int          BEAT_WAIT  = 0,
  parameter int          INT_WIDTH  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  vproc_mem_responder_if.slave  bus
);

  localparam logic [WAIT_CNT_W-1:0] FIRST_CNT = WAIT_CNT_W'(FIRST_WAIT);
  localparam logic [WAIT_CNT_W-1:0] BEAT_CNT  = WAIT_CNT_W'(BEAT_WAIT);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

  logic [1:0]            r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic                  r_in_burst;
  logic                  r_wr_ack;
  logic                  r_rd_ack;
  rd_src_e               r_rd_src;
  logic [31:0]           r_rd_word;
  logic [INT_WIDTH-1:0]  r_int;
  logic [15:0]           r_err_cnt;

  logic                  w_req;
  logic [WAIT_CNT_W-1:0] w_load;
  logic                  w_enter_ack;
  logic                  w_is_ctrl;
  logic                  w_is_mem;
  logic                  w_error;
  logic [31:0]           w_ram_rdata;

  assign w_req     = bus.rd | bus.we;
  // BurstFirst lets the master restart burst timing even if the last burst was cut short.
  assign w_load    = (!r_in_burst || bus.burst_first) ? FIRST_CNT : BEAT_CNT;
  assign w_is_ctrl = (bus.addr == CTRL_ADDR);
  assign w_is_mem  = !w_is_ctrl && (bus.addr[31:MEM_AWIDTH] == BASE_ADDR[31:MEM_AWIDTH]);
  assign w_error   = (bus.rd & bus.we) | (!w_is_ctrl && !w_is_mem);

  // NOTE: reset is folded in here so an access abandoned by reset cannot write
  // the RAM on the very edge it would have been acknowledged.
  assign w_enter_ack = !i_reset &&
                       (((r_state == ST_IDLE) && w_req && (w_load == '0)) ||
                        ((r_state == ST_WAIT) && (r_cnt == CNT_ONE)));

  vproc_mem_ram #(
    .AWIDTH (MEM_AWIDTH),
    .DWIDTH (32)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_enter_ack && bus.we && w_is_mem),
    .i_re    (w_enter_ack && !bus.we && w_is_mem),
    .i_addr  (bus.addr[MEM_AWIDTH-1:0]),
    .i_wdata (bus.data_out),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_in_burst <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_ack   <= 1'b0;
      r_rd_src   <= RD_SRC_REG;
      r_rd_word  <= '0;
      r_int      <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_wr_ack <= w_enter_ack && bus.we;
      r_rd_ack <= w_enter_ack && !bus.we;

      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_cnt   <= w_load;
            r_state <= (w_load == '0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= ST_ACK;
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_enter_ack) begin
        r_in_burst <= (bus.burst > 12'd1) && !bus.burst_last;
        if (!bus.we) begin
          r_rd_src  <= w_is_mem ? RD_SRC_RAM : RD_SRC_REG;
          r_rd_word <= w_is_ctrl ? 32'(r_int) : 32'h0;
        end
        if (bus.we && w_is_ctrl) r_int <= bus.data_out[INT_WIDTH-1:0];
        if (w_error && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign bus.data_in   = (r_rd_src == RD_SRC_RAM) ? w_ram_rdata : r_rd_word;
  assign bus.wr_ack    = r_wr_ack;
  assign bus.rd_ack    = r_rd_ack;
  assign bus.interrupt = r_int;
  assign bus.err_count = r_err_cnt;

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Directed bench for vproc_mem_responder: vector table for single/burst/ctrl/miss
// accesses, hand sequences for reset abandonment and a short random model check.
module tb_vproc_mem_responder;
  import vproc_mem_responder_pkg::*;

  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] CTRL = DEFAULT_CTRL_ADDR;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vproc_mem_responder_if #(.INT_WIDTH(3)) bus ();

  vproc_mem_responder #(
    .MEM_AWIDTH (AW),
    .BASE_ADDR  (BASE),
    .CTRL_ADDR  (CTRL),
    .FIRST_WAIT (2),
    .BEAT_WAIT  (0),
    .INT_WIDTH  (3)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is #1 after a posedge. Drives the request, counts edges until an ack
  // is seen (bounded), then samples one more edge to confirm the ack dropped.
  task automatic access(input logic we, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [11:0] burst,
                        input logic first, input logic last,
                        output int lat, output logic wr_seen, output logic rd_seen,
                        output logic [31:0] rdata, output logic [31:0] rdata_after,
                        output logic stuck);
    bus.addr = addr;  bus.data_out = wdata;  bus.burst = burst;
    bus.burst_first = first;  bus.burst_last = last;
    bus.we = we;  bus.rd = rd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(bus.wr_ack || bus.rd_ack) && lat < 20);
    wr_seen = bus.wr_ack;
    rd_seen = bus.rd_ack;
    rdata   = bus.data_in;
    @(posedge clk); #1;
    stuck       = bus.wr_ack | bus.rd_ack;
    rdata_after = bus.data_in;
  endtask

  typedef struct {
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [11:0] burst;
    logic        first;
    logic        last;
    int          lat;
    logic        chk_rd;
    logic [31:0] rdata;
    logic [15:0] err;
    logic [2:0]  irq;
  } vec_t;

  vec_t vecs[15];

  logic [31:0] mdl   [16];
  logic        mdl_ok[16];

  initial begin
    int          lat;
    logic        wr_seen, rd_seen, stuck;
    logic [31:0] rdata, rdata_after;

    vecs[0]  = '{1'b1, 1'b0, BASE + 32'd5,     32'h1234_5678, 12'd1, 1'b1, 1'b1, 3, 1'b0, 32'h0,          16'd0, 3'd0};
    vecs[1]  = '{1'b0, 1'b1, BASE + 32'd5,     32'h0,         12'd1, 1'b1, 1'b1, 3, 1'b1, 32'h1234_5678, 16'd0, 3'd0};
    vecs[2]  = '{1'b1, 1'b0, BASE + 32'h10,    32'hA000_0010, 12'd4, 1'b1, 1'b0, 3, 1'b0, 32'h0,          16'd0, 3'd0};
    vecs[3]  = '{1'b1, 1'b0, BASE + 32'h11,    32'hA000_0011, 12'd3, 1'b0, 1'b0, 1, 1'b0, 32'h0,          16'd0, 3'd0};
    vecs[4]  = '{1'b1, 1'b0, BASE + 32'h12,    32'hA000_0012, 12'd2, 1'b0, 1'b0, 1, 1'b0, 32'h0,          16'd0, 3'd0};
    vecs[5]  = '{1'b1, 1'b0, BASE + 32'h13,    32'hA000_0013, 12'd1, 1'b0, 1'b1, 1, 1'b0, 32'h0,          16'd0, 3'd0};
    vecs[6]  = '{1'b0, 1'b1, BASE + 32'h10,    32'h0,         12'd1, 1'b1, 1'b1, 3, 1'b1, 32'hA000_0010, 16'd0, 3'd0};
    vecs[7]  = '{1'b0, 1'b1, BASE + 32'h11,    32'h0,         12'd1, 1'b1, 1'b1, 3, 1'b1, 32'hA000_0011, 16'd0, 3'd0};
    vecs[8]  = '{1'b0, 1'b1, BASE + 32'h12,    32'h0,         12'd1, 1'b1, 1'b1, 3, 1'b1, 32'hA000_0012, 16'd0, 3'd0};
    vecs[9]  = '{1'b0, 1'b1, BASE + 32'h13,    32'h0,         12'd1, 1'b1, 1'b1, 3, 1'b1, 32'hA000_0013, 16'd0, 3'd0};
    vecs[10] = '{1'b1, 1'b0, CTRL,             32'h0000_00FD, 12'd1, 1'b1, 1'b1, 3, 1'b0, 32'h0,          16'd0, 3'd5};
    vecs[11] = '{1'b0, 1'b1, CTRL,             32'h0,         12'd1, 1'b1, 1'b1, 3, 1'b1, 32'h0000_0005, 16'd0, 3'd5};
    vecs[12] = '{1'b0, 1'b1, BASE + 32'd1024,  32'h0,         12'd1, 1'b1, 1'b1, 3, 1'b1, 32'h0,          16'd1, 3'd5};
    vecs[13] = '{1'b1, 1'b1, BASE + 32'd7,     32'h0000_CAFE, 12'd1, 1'b1, 1'b1, 3, 1'b0, 32'h0,          16'd2, 3'd5};
    vecs[14] = '{1'b0, 1'b1, BASE + 32'd7,     32'h0,         12'd1, 1'b1, 1'b1, 3, 1'b1, 32'h0000_CAFE, 16'd2, 3'd5};

    bus.addr = '0;  bus.data_out = '0;  bus.burst = '0;
    bus.burst_first = 1'b0;  bus.burst_last = 1'b0;
    bus.we = 1'b0;  bus.rd = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
    check("rst_rd_ack", 32'(bus.rd_ack), 32'd0);
    check("rst_data_in", bus.data_in, 32'h0);
    check("rst_interrupt", 32'(bus.interrupt), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    reset = 1'b0;

    // Vector table: singles, 4-beat burst, ctrl register, miss, RD+WE
    for (int i = 0; i < 15; i++) begin
      access(vecs[i].we, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].burst,
             vecs[i].first, vecs[i].last, lat, wr_seen, rd_seen, rdata, rdata_after, stuck);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_wr_ack", i), 32'(wr_seen), 32'(vecs[i].we));
      check($sformatf("v%0d_rd_ack", i), 32'(rd_seen), 32'(!vecs[i].we));
      check($sformatf("v%0d_ack_one_cycle", i), 32'(stuck), 32'd0);
      if (vecs[i].chk_rd) begin
        check($sformatf("v%0d_data_in", i), rdata, vecs[i].rdata);
        check($sformatf("v%0d_data_in_hold", i), rdata_after, vecs[i].rdata);
      end
      check($sformatf("v%0d_err_count", i), 32'(bus.err_count), 32'(vecs[i].err));
      check($sformatf("v%0d_interrupt", i), 32'(bus.interrupt), 32'(vecs[i].irq));
    end

    // Reset on the edge that would enter ACK for a write: no ack, no write
    bus.we = 1'b0;  bus.rd = 1'b0;
    @(posedge clk); #1;
    bus.addr = BASE + 32'd5;  bus.data_out = 32'hDEAD_BEEF;
    bus.burst = 12'd1;  bus.burst_first = 1'b1;  bus.burst_last = 1'b1;
    bus.we = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wait_no_ack", 32'(bus.wr_ack | bus.rd_ack), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_wr_ack", 32'(bus.wr_ack), 32'd0);
    check("abort_rd_ack", 32'(bus.rd_ack), 32'd0);
    check("abort_interrupt", 32'(bus.interrupt), 32'd0);
    check("abort_err_count", 32'(bus.err_count), 32'd0);
    check("abort_data_in", bus.data_in, 32'h0);
    bus.we = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort_idle_%0d", k), 32'(bus.wr_ack | bus.rd_ack), 32'd0);
    end
    access(1'b0, 1'b1, BASE + 32'd5, 32'h0, 12'd1, 1'b1, 1'b1,
           lat, wr_seen, rd_seen, rdata, rdata_after, stuck);
    check("reissue_latency", 32'(lat), 32'd3);
    check("reissue_rd_ack", 32'(rd_seen), 32'd1);
    check("reissue_one_cycle", 32'(stuck), 32'd0);
    check("reissue_data_in", rdata, 32'h1234_5678);

    // Random singles against a word model in a 16-word window
    for (int j = 0; j < 16; j++) mdl_ok[j] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      int          idx;
      logic        do_rd;
      logic [31:0] wd;
      idx   = int'($urandom_range(0, 15));
      do_rd = mdl_ok[idx] && ($urandom_range(0, 1) == 1);
      wd    = $urandom;
      access(!do_rd, do_rd, BASE + 32'h100 + 32'(idx), wd, 12'd1, 1'b1, 1'b1,
             lat, wr_seen, rd_seen, rdata, rdata_after, stuck);
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'd3);
      check($sformatf("rnd%0d_ack_kind", n), {30'd0, wr_seen, rd_seen}, do_rd ? 32'd1 : 32'd2);
      check($sformatf("rnd%0d_ack_one_cycle", n), 32'(stuck), 32'd0);
      if (do_rd) begin
        check($sformatf("rnd%0d_data_in", n), rdata, mdl[idx]);
      end else begin
        mdl[idx]    = wd;
        mdl_ok[idx] = 1'b1;
      end
    end
    check("rnd_err_count", 32'(bus.err_count), 32'd0);

    bus.we = 1'b0;  bus.rd = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
